// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two requesters (CPU, loader), the arbiter and RAM port A.
// slave = arbiter side, master = requester/RAM side.
interface ram_arbiter_if #(
  parameter int ADDR_WIDTH = 15
);
  logic                  req0, req1;
  logic [1:0]            we0, we1;
  logic [2:0]            re0, re1;
  logic [ADDR_WIDTH-1:0] addr0, addr1;
  logic [31:0]           din0, din1;
  logic                  gnt0, gnt1;
  logic                  rvalid0, rvalid1;
  logic [31:0]           dout0, dout1;
  logic [1:0]            weA;
  logic [2:0]            reA;
  logic [ADDR_WIDTH-1:0] addrA;
  logic [31:0]           dinA;
  logic [31:0]           doutA;

  modport slave (
    input  req0, req1, we0, we1, re0, re1, addr0, addr1, din0, din1, doutA,
    output gnt0, gnt1, rvalid0, rvalid1, dout0, dout1, weA, reA, addrA, dinA
  );

  modport master (
    output req0, req1, we0, we1, re0, re1, addr0, addr1, din0, din1, doutA,
    input  gnt0, gnt1, rvalid0, rvalid1, dout0, dout1, weA, reA, addrA, dinA
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester arbiter for a single RAM port with burst-limited ownership.
// Optional macro RAM_ARBITER_RR_EN: IDLE tie-break alternates instead of favouring requester 0.
//
// state | meaning
// IDLE  | no request last cycle, cnt = 0
// OWN0  | requester 0 won last cycle, cnt = consecutive grants
// OWN1  | requester 1 won last cycle, cnt = consecutive grants
module ram_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int MAX_BURST  = 4
) (
  input  logic            clk,
  input  logic            rst,
  ram_arbiter_if.slave    bus
);
  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rd_pend_q, rd_owner_q;
  logic            any_req, win, tie_win;

`ifdef RAM_ARBITER_RR_EN
  logic            last_win_q;
  assign tie_win = ~last_win_q;
`else
  assign tie_win = 1'b0;
`endif

  // win: 0 = requester 0, 1 = requester 1; only meaningful when any_req
  always_comb begin
    any_req = (bus.req0 | bus.req1) & rst;
    win     = bus.req1;
    if (bus.req0 && bus.req1) begin
      case (state_q)
        OWN0:    win = (cnt_q == CNT_MAX);
        OWN1:    win = (cnt_q != CNT_MAX);
        default: win = tie_win;
      endcase
    end
  end

  always_comb begin
    bus.gnt0  = any_req & ~win;
    bus.gnt1  = any_req & win;
    bus.weA   = '0;
    bus.reA   = '0;
    bus.addrA = '0;
    bus.dinA  = '0;
    if (any_req) begin
      bus.weA   = win ? bus.we1   : bus.we0;
      bus.reA   = win ? bus.re1   : bus.re0;
      bus.addrA = win ? bus.addr1 : bus.addr0;
      bus.dinA  = win ? bus.din1  : bus.din0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!any_req) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if ((win && state_q == OWN1) || (!win && state_q == OWN0)) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end else begin
      state_d = win ? OWN1 : OWN0;
      cnt_d   = CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_pend_q  <= any_req & (bus.reA != 3'b000);
      rd_owner_q <= win;
    end
  end

`ifdef RAM_ARBITER_RR_EN
  // reset to 1 so requester 0 takes the first tie
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         last_win_q <= 1'b1;
    else if (any_req) last_win_q <= win;
  end
`endif

  always_comb begin
    bus.rvalid0 = rd_pend_q & ~rd_owner_q;
    bus.rvalid1 = rd_pend_q & rd_owner_q;
    bus.dout0   = bus.rvalid0 ? bus.doutA : '0;
    bus.dout1   = bus.rvalid1 ? bus.doutA : '0;
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a byte-addressed RAM model on port A.
module tb_ram_arbiter;
  localparam int AW = 15;
`ifdef RAM_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  ram_arbiter_if #(.ADDR_WIDTH(AW)) bus ();
  ram_arbiter #(.ADDR_WIDTH(AW), .MAX_BURST(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  logic [7:0] mem [0:(1<<AW)-1];

  function automatic logic [31:0] rd_data(input logic [AW-1:0] a, input logic [2:0] re);
    logic [31:0] d;
    d = '0;
    case (re[1:0])
      2'b01: d = re[2] ? {{24{mem[a][7]}}, mem[a]} : {24'h0, mem[a]};
      2'b10: d = re[2] ? {{16{mem[a+AW'(1)][7]}}, mem[a+AW'(1)], mem[a]}
                       : {16'h0, mem[a+AW'(1)], mem[a]};
      2'b11: d = {mem[a+AW'(3)], mem[a+AW'(2)], mem[a+AW'(1)], mem[a]};
      default: d = '0;
    endcase
    return d;
  endfunction

  // RAM: synchronous write, read data one cycle after the read is issued
  always @(posedge clk) begin
    if (!rst) begin
      mem[15'h10] <= 8'hEF; mem[15'h11] <= 8'hBE; mem[15'h12] <= 8'hAD; mem[15'h13] <= 8'hDE;
      mem[15'h20] <= 8'h11; mem[15'h21] <= 8'h00; mem[15'h22] <= 8'h00; mem[15'h23] <= 8'h00;
      mem[15'h24] <= 8'h22; mem[15'h25] <= 8'h00; mem[15'h26] <= 8'h00; mem[15'h27] <= 8'h00;
      bus.doutA <= '0;
    end else begin
      case (bus.weA)
        2'b01: mem[bus.addrA] <= bus.dinA[7:0];
        2'b10: begin
          mem[bus.addrA]        <= bus.dinA[7:0];
          mem[bus.addrA+AW'(1)] <= bus.dinA[15:8];
        end
        2'b11: begin
          mem[bus.addrA]        <= bus.dinA[7:0];
          mem[bus.addrA+AW'(1)] <= bus.dinA[15:8];
          mem[bus.addrA+AW'(2)] <= bus.dinA[23:16];
          mem[bus.addrA+AW'(3)] <= bus.dinA[31:24];
        end
        default: ;
      endcase
      bus.doutA <= (bus.reA[1:0] != 2'b00) ? rd_data(bus.addrA, bus.reA) : 32'h0;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_reqs();
    bus.req0 = 1'b0; bus.we0 = 2'b00; bus.re0 = 3'b000; bus.addr0 = '0; bus.din0 = '0;
    bus.req1 = 1'b0; bus.we1 = 2'b00; bus.re1 = 3'b000; bus.addr1 = '0; bus.din1 = '0;
  endtask

  initial begin
    rst = 1'b0;
    idle_reqs();
    bus.req0 = 1'b1; bus.re0 = 3'b111;
    bus.req1 = 1'b1; bus.we1 = 2'b11;
    #2;
    check_val("rst_gnt0",    32'(bus.gnt0),    32'd0);
    check_val("rst_gnt1",    32'(bus.gnt1),    32'd0);
    check_val("rst_weA",     32'(bus.weA),     32'd0);
    check_val("rst_reA",     32'(bus.reA),     32'd0);
    check_val("rst_rvalid0", 32'(bus.rvalid0), 32'd0);
    check_val("rst_rvalid1", 32'(bus.rvalid1), 32'd0);
    check_val("rst_dout0",   bus.dout0,        32'h0);
    check_val("rst_dout1",   bus.dout1,        32'h0);
    next_cycle();
    next_cycle();

    // single signed word read, first cycle after reset release
    rst = 1'b1;
    idle_reqs();
    bus.req0 = 1'b1; bus.re0 = 3'b111; bus.addr0 = 15'h10;
    sample();
    check_val("rd_gnt0",  32'(bus.gnt0),  32'd1);
    check_val("rd_gnt1",  32'(bus.gnt1),  32'd0);
    check_val("rd_reA",   32'(bus.reA),   32'd7);
    check_val("rd_addrA", 32'(bus.addrA), 32'h10);
    next_cycle();
    idle_reqs();
    sample();
    check_val("rd_rvalid0", 32'(bus.rvalid0), 32'd1);
    check_val("rd_dout0",   bus.dout0,        32'hDEADBEEF);
    check_val("rd_rvalid1", 32'(bus.rvalid1), 32'd0);
    check_val("rd_dout1",   bus.dout1,        32'h0);
    next_cycle();

    // starvation guard: both no-op requests held from IDLE
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int c = 0; c < 9; c++) begin
      sample();
      check_val($sformatf("burst_gnt0_c%0d", c), 32'(bus.gnt0), (c < 4 || c == 8) ? 32'd1 : 32'd0);
      check_val($sformatf("burst_gnt1_c%0d", c), 32'(bus.gnt1), (c >= 4 && c < 8) ? 32'd1 : 32'd0);
      check_val($sformatf("burst_en_c%0d", c),   32'({bus.weA, bus.reA}), 32'd0);
      next_cycle();
    end
    idle_reqs();
    next_cycle();

    // alternating reads, no bubble
    bus.req0 = 1'b1; bus.re0 = 3'b111; bus.addr0 = 15'h20;
    sample();
    check_val("alt_gnt0", 32'(bus.gnt0), 32'd1);
    next_cycle();
    idle_reqs();
    bus.req1 = 1'b1; bus.re1 = 3'b111; bus.addr1 = 15'h24;
    sample();
    check_val("alt_gnt1",    32'(bus.gnt1),    32'd1);
    check_val("alt_rvalid0", 32'(bus.rvalid0), 32'd1);
    check_val("alt_dout0",   bus.dout0,        32'h11);
    check_val("alt_rv1_c1",  32'(bus.rvalid1), 32'd0);
    next_cycle();
    idle_reqs();
    sample();
    check_val("alt_rvalid1", 32'(bus.rvalid1), 32'd1);
    check_val("alt_dout1",   bus.dout1,        32'h22);
    check_val("alt_rv0_c2",  32'(bus.rvalid0), 32'd0);
    check_val("alt_dout0_c2", bus.dout0,       32'h0);
    next_cycle();

    // byte write by loader, then LBU readback by CPU
    bus.req1 = 1'b1; bus.we1 = 2'b01; bus.addr1 = 15'h3; bus.din1 = 32'hAB;
    sample();
    check_val("wr_gnt1",  32'(bus.gnt1),  32'd1);
    check_val("wr_weA",   32'(bus.weA),   32'd1);
    check_val("wr_reA",   32'(bus.reA),   32'd0);
    check_val("wr_addrA", 32'(bus.addrA), 32'h3);
    check_val("wr_dinA",  bus.dinA,       32'hAB);
    next_cycle();
    idle_reqs();
    sample();
    check_val("wr_rvalid0", 32'(bus.rvalid0), 32'd0);
    check_val("wr_rvalid1", 32'(bus.rvalid1), 32'd0);
    next_cycle();
    bus.req0 = 1'b1; bus.re0 = 3'b001; bus.addr0 = 15'h3;
    sample();
    check_val("lbu_gnt0", 32'(bus.gnt0), 32'd1);
    check_val("lbu_reA",  32'(bus.reA),  32'd1);
    next_cycle();
    idle_reqs();
    sample();
    check_val("lbu_rvalid0", 32'(bus.rvalid0), 32'd1);
    check_val("lbu_dout0",   bus.dout0,        32'hAB);
    next_cycle();

    // reset while a read is in flight
    bus.req0 = 1'b1; bus.re0 = 3'b111; bus.addr0 = 15'h10;
    sample();
    check_val("rr_gnt0", 32'(bus.gnt0), 32'd1);
    #1;
    rst = 1'b0;
    bus.req1 = 1'b1;
    #1;
    check_val("rr_low_gnt0", 32'(bus.gnt0), 32'd0);
    check_val("rr_low_gnt1", 32'(bus.gnt1), 32'd0);
    check_val("rr_low_reA",  32'(bus.reA),  32'd0);
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      sample();
      check_val($sformatf("rr_rv0_c%0d", c),   32'(bus.rvalid0), 32'd0);
      check_val($sformatf("rr_gnt0_c%0d", c),  32'(bus.gnt0),    32'd0);
      check_val($sformatf("rr_gnt1_c%0d", c),  32'(bus.gnt1),    32'd0);
    end
    next_cycle();
    rst = 1'b1;
    idle_reqs();
    sample();
    check_val("rr_post_rv0",   32'(bus.rvalid0), 32'd0);
    check_val("rr_post_rv1",   32'(bus.rvalid1), 32'd0);
    check_val("rr_post_dout0", bus.dout0,        32'h0);
    next_cycle();
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    sample();
    check_val("rr_idle_gnt0", 32'(bus.gnt0), 32'd1);
    check_val("rr_idle_gnt1", 32'(bus.gnt1), 32'd0);
    next_cycle();
    idle_reqs();
    next_cycle();

    // IDLE tie-break after requester 0 won alone
    bus.req0 = 1'b1;
    sample();
    check_val("tie_solo_gnt0", 32'(bus.gnt0), 32'd1);
    next_cycle();
    idle_reqs();
    sample();
    check_val("tie_idle_gnt", 32'({bus.gnt0, bus.gnt1}), 32'd0);
    next_cycle();
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    sample();
    check_val("tie_gnt0", 32'(bus.gnt0), RR ? 32'd0 : 32'd1);
    check_val("tie_gnt1", 32'(bus.gnt1), RR ? 32'd1 : 32'd0);
    next_cycle();
    idle_reqs();
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
